alu_issue_stage: RTL and testbench

Sequential issue/capture stage directly upstream of the 32-bit ALU in the KGP miniRISC execute path. It accepts one decoded operation (opcode, two operands, destination tag) over a valid/ready handshake and registers the ALU operand and control inputs. After a programmable settle latency it captures the ALU result and flags, updates the architectural Z/N/C flag register, and presents the result to writeback over a second valid/ready handshake. It isolates the combinational ALU between registers and provides backpressure, flush and sticky-carry semantics.

---
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/capture stage in front of the combinational 32-bit ALU: registers operands,
// waits ALU_LAT cycles, samples result and flags, and hands the result to writeback.
module alu_issue_stage #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        alu_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [4:0]  rd_q;
  logic        accept;
  logic        capture;
  logic        res_valid_n;

  // A draining HOLD slot can take the next operation in the same cycle.
  assign in_ready = (state == IDLE) | ((state == HOLD) & res_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    capture     = 1'b0;
    res_valid_n = res_valid;
    if (flush) begin
      state_n     = IDLE;
      cnt_n       = 2'd0;
      res_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n = EXEC;
            cnt_n   = CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt != 2'd0) begin
            cnt_n = cnt - 2'd1;
          end else begin
            capture     = 1'b1;
            res_valid_n = 1'b1;
            state_n     = HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_n = 1'b0;
            if (accept) begin
              state_n = EXEC;
              cnt_n   = CNT_INIT;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: begin
          state_n     = IDLE;
          cnt_n       = 2'd0;
          res_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rd_q      <= 5'd0;
      alu_in1   <= 32'd0;
      alu_in2   <= 32'd0;
      alu_ctrl  <= 3'd0;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_rd    <= 5'd0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      res_valid <= res_valid_n;
      if (accept) begin
        alu_in1  <= in_a;
        alu_in2  <= in_b;
        alu_ctrl <= in_op;
        rd_q     <= in_rd;
      end
      // Carry is sticky: only an add may change it.
      if (capture) begin
        res_data <= alu_out;
        res_rd   <= rd_q;
        flag_z   <= alu_zero;
        flag_n   <= alu_msb;
        if (alu_ctrl == 3'd0) begin
          flag_c <= alu_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: three instances (ALU_LAT 1..3) driven by a behavioural ALU,
// checked against hand-computed result vectors and multi-cycle corner sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [2:0]  in_op     [3];
  logic [31:0] in_a      [3];
  logic [31:0] in_b      [3];
  logic [4:0]  in_rd     [3];
  logic [31:0] alu_in1   [3];
  logic [31:0] alu_in2   [3];
  logic [2:0]  alu_ctrl  [3];
  logic [31:0] alu_out   [3];
  logic        alu_zero  [3];
  logic        alu_msb   [3];
  logic        alu_carry [3];
  logic        res_valid [3];
  logic        res_ready [3];
  logic [31:0] res_data  [3];
  logic [4:0]  res_rd    [3];
  logic        flag_z    [3];
  logic        flag_n    [3];
  logic        flag_c    [3];

  int total;
  int bad;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
  } vec_t;

  vec_t vecs [11];

  // Behavioural ALU: {carry, zero, msb, result}; diff reports carry as "no borrow".
  function automatic logic [34:0] alu_model(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        cy;
    cy = 1'b0;
    case (c)
      3'd0: {cy, r} = {1'b0, a} + {1'b0, b};
      3'd1: r = ~a;
      3'd2: r = a << b[4:0];
      3'd3: r = a >> b[4:0];
      3'd4: r = $unsigned($signed(a) >>> b[4:0]);
      3'd5: begin r = a - b; cy = (a >= b); end
      3'd6: r = a & b;
      default: r = a ^ b;
    endcase
    return {cy, (r == 32'd0), r[31], r};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_issue_stage #(.ALU_LAT(g + 1)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_op     (in_op[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .in_rd     (in_rd[g]),
      .alu_in1   (alu_in1[g]),
      .alu_in2   (alu_in2[g]),
      .alu_ctrl  (alu_ctrl[g]),
      .alu_out   (alu_out[g]),
      .alu_zero  (alu_zero[g]),
      .alu_msb   (alu_msb[g]),
      .alu_carry (alu_carry[g]),
      .res_valid (res_valid[g]),
      .res_ready (res_ready[g]),
      .res_data  (res_data[g]),
      .res_rd    (res_rd[g]),
      .flag_z    (flag_z[g]),
      .flag_n    (flag_n[g]),
      .flag_c    (flag_c[g])
    );
    assign {alu_carry[g], alu_zero[g], alu_msb[g], alu_out[g]} =
      alu_model(alu_ctrl[g], alu_in1[g], alu_in2[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    in_op[d]    = op;
    in_a[d]     = a;
    in_b[d]     = b;
    in_rd[d]    = rd;
    in_valid[d] = 1'b1;
  endtask

  // One full transaction on the ALU_LAT=1 instance, called at a negedge with the stage idle.
  task automatic runOne(input vec_t v);
    checkOutput("in_ready_before", 32'(in_ready[0]), 32'd1);
    applyStimulus(0, v.op, v.a, v.b, v.rd);
    @(negedge clk);
    in_valid[0] = 1'b0;
    checkOutput("res_valid_early", 32'(res_valid[0]), 32'd0);
    @(negedge clk);
    checkOutput("res_valid", 32'(res_valid[0]), 32'd1);
    checkOutput("res_data", res_data[0], v.res);
    checkOutput("res_rd", 32'(res_rd[0]), 32'(v.rd));
    checkOutput("flag_z", 32'(flag_z[0]), 32'(v.z));
    checkOutput("flag_n", 32'(flag_n[0]), 32'(v.n));
    checkOutput("flag_c", 32'(flag_c[0]), 32'(v.c));
    @(negedge clk);
    checkOutput("res_valid_drop", 32'(res_valid[0]), 32'd0);
    checkOutput("in_ready_after", 32'(in_ready[0]), 32'd1);
  endtask

  initial begin
    int acc_cycle [4];
    int idx;
    int got;
    vec_t post;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      flush[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_op[d]     = 3'd0;
      in_a[d]      = 32'd0;
      in_b[d]      = 32'd0;
      in_rd[d]     = 5'd0;
      res_ready[d] = 1'b1;
    end

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2,  32'h00F000F0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 5'd3,  32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'd7, 32'hAAAA5555, 32'hFFFF0000, 5'd4,  32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 32'h00000001, 32'h00000004, 5'd5,  32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 32'h00000005, 32'h00000003, 5'd6,  32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 32'hFFFFFFFF, 32'h00000000, 5'd7,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 32'h80000000, 32'h00000004, 5'd8,  32'hF8000000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd3, 32'h80000000, 32'h00000004, 5'd31, 32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'd5, 32'h00000003, 32'h00000005, 5'd10, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_in_ready", 32'(in_ready[d]), 32'd1);
      checkOutput("rst_res_valid", 32'(res_valid[d]), 32'd0);
      checkOutput("rst_res_data", res_data[d], 32'd0);
      checkOutput("rst_alu_in1", alu_in1[d], 32'd0);
      checkOutput("rst_alu_ctrl", 32'(alu_ctrl[d]), 32'd0);
      checkOutput("rst_flags", {29'd0, flag_z[d], flag_n[d], flag_c[d]}, 32'd0);
    end
    @(negedge clk);

    for (int i = 0; i < 11; i++) runOne(vecs[i]);

    // Flush while op0 5+7 sits in EXEC; the op offered during the flush must be dropped.
    applyStimulus(0, 3'd0, 32'd5, 32'd7, 5'd3);
    @(negedge clk);
    checkOutput("flush_in_exec", 32'(in_ready[0]), 32'd0);
    applyStimulus(0, 3'd6, 32'h99, 32'h0F, 5'd4);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    checkOutput("flush_res_valid", 32'(res_valid[0]), 32'd0);
    checkOutput("flush_flags", {29'd0, flag_z[0], flag_n[0], flag_c[0]}, 32'b011);
    checkOutput("flush_res_data", res_data[0], 32'hFFFFFFFE);
    checkOutput("flush_res_rd", 32'(res_rd[0]), 32'd10);
    checkOutput("flush_idle", 32'(in_ready[0]), 32'd1);
    checkOutput("flush_alu_in1", alu_in1[0], 32'd5);
    @(negedge clk);
    checkOutput("flush_no_pulse", 32'(res_valid[0]), 32'd0);
    applyStimulus(0, 3'd0, 32'h123, 32'd1, 5'd9);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    checkOutput("flush_idle_no_accept", alu_in1[0], 32'd5);
    checkOutput("flush_idle_ready", 32'(in_ready[0]), 32'd1);
    post = '{3'd6, 32'h000000FF, 32'h0000000F, 5'd7, 32'h0000000F, 1'b0, 1'b0, 1'b1};
    runOne(post);

    // Backpressure on the ALU_LAT=3 instance, with a second op waiting throughout.
    res_ready[2] = 1'b0;
    applyStimulus(2, 3'd7, 32'hAAAA5555, 32'hFFFF0000, 5'd12);
    @(negedge clk);
    applyStimulus(2, 3'd0, 32'd1, 32'd2, 5'd9);
    checkOutput("bp_wait1", 32'(res_valid[2]), 32'd0);
    @(negedge clk);
    checkOutput("bp_wait2", 32'(res_valid[2]), 32'd0);
    @(negedge clk);
    checkOutput("bp_wait3", 32'(res_valid[2]), 32'd0);
    @(negedge clk);
    checkOutput("bp_valid", 32'(res_valid[2]), 32'd1);
    checkOutput("bp_rd", 32'(res_rd[2]), 32'd12);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_hold_valid", 32'(res_valid[2]), 32'd1);
      checkOutput("bp_hold_data", res_data[2], 32'h55555555);
      checkOutput("bp_hold_ready", 32'(in_ready[2]), 32'd0);
      checkOutput("bp_hold_alu_in1", alu_in1[2], 32'hAAAA5555);
      @(negedge clk);
    end
    res_ready[2] = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready[2]), 32'd1);
    @(negedge clk);
    in_valid[2] = 1'b0;
    checkOutput("bp_drain_valid", 32'(res_valid[2]), 32'd0);
    checkOutput("bp_overlap_alu_in1", alu_in1[2], 32'd1);
    checkOutput("bp_overlap_ctrl", 32'(alu_ctrl[2]), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("bp_second_valid", 32'(res_valid[2]), 32'd1);
    checkOutput("bp_second_data", res_data[2], 32'd3);
    checkOutput("bp_second_rd", 32'(res_rd[2]), 32'd9);
    @(negedge clk);

    // Back-to-back on the ALU_LAT=2 instance: one op per three cycles, in order.
    idx = 0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid[1] && res_ready[1]) begin
        if (got < 4) begin
          checkOutput("b2b_data", res_data[1], 32'(101 + got));
          checkOutput("b2b_rd", 32'(res_rd[1]), 32'(got + 1));
        end
        got++;
      end
      if (idx < 4) begin
        applyStimulus(1, 3'd0, 32'(idx + 1), 32'd100, 5'(idx + 1));
        if (in_ready[1]) begin
          acc_cycle[idx] = c;
          idx++;
        end
      end else begin
        in_valid[1] = 1'b0;
      end
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    checkOutput("b2b_accepts", 32'(idx), 32'd4);
    checkOutput("b2b_results", 32'(got), 32'd4);
    if (idx == 4) begin
      for (int k = 0; k < 4; k++)
        checkOutput("b2b_accept_cycle", 32'(acc_cycle[k] - acc_cycle[0]), 32'(3 * k));
    end

    // Asynchronous reset between edges while a result sits in HOLD.
    res_ready[0] = 1'b0;
    applyStimulus(0, 3'd0, 32'hFFFFFFFF, 32'd1, 5'd30);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("arst_hold_valid", 32'(res_valid[0]), 32'd1);
    checkOutput("arst_hold_flags", {29'd0, flag_z[0], flag_n[0], flag_c[0]}, 32'b101);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_res_valid", 32'(res_valid[0]), 32'd0);
    checkOutput("arst_flags", {29'd0, flag_z[0], flag_n[0], flag_c[0]}, 32'd0);
    checkOutput("arst_res_data", res_data[0], 32'd0);
    #1 rst = 1'b0;
    res_ready[0] = 1'b1;
    @(negedge clk);
    checkOutput("arst_in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("arst_no_valid", 32'(res_valid[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
